out_buff: RTL and testbench
===========================

OUT_BUFF -- requirements
Module: out_buff

Interface
- REQ-001 SHALL have no parameters; geometry is fixed at 8x8 bytes, 16 column writes in and 16 words out.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  asynchronous, active-high reset.
- REQ-004 in_valid  input  1  column write request.
- REQ-005 in_ready  output  1  column write accepted when in_valid && in_ready.
- REQ-006 in_data  input  32  four bytes; byte k is in_data[8k+7:8k], k=0..3.
- REQ-007 out_valid  output  1  drain word available.
- REQ-008 out_ready  input  1  consumer accepts word when out_valid && out_ready.
- REQ-009 out_data  output  32  drain word; byte b is out_data[8b+7:8b].
- REQ-010 out_addr  output  4  index of the current drain word, 0..15.
- REQ-011 out_last  output  1  high with out_valid when out_addr==15.
- REQ-012 frame_done  output  1  one-cycle pulse after the final drain transfer.

Function
- REQ-013 Storage SHALL be 64 bytes organised as mem[row 0..7][col 0..7].
- REQ-014 The FSM SHALL have two states: FILL (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
- REQ-015 In FILL, an accepted column c (wr_cnt, 0..15) SHALL write byte k to mem[c/8 + 2k][c%8] for k=0..3.
- REQ-016 Each accepted column SHALL increment wr_cnt; acceptance at wr_cnt==15 SHALL set wr_cnt=0 and enter DRAIN on the next cycle.
- REQ-017 In DRAIN, out_data byte b SHALL equal mem[rd_cnt/2][(rd_cnt%2)*4 + b]; out_addr SHALL equal rd_cnt.
- REQ-018 out_data SHALL be combinational from storage and rd_cnt, giving zero added latency while out_valid is high.
- REQ-019 out_valid, out_data and out_addr SHALL remain stable while out_valid && !out_ready (no drop, no advance).
- REQ-020 A transfer SHALL increment rd_cnt; a transfer at rd_cnt==15 SHALL set rd_cnt=0, return to FILL and assert frame_done on the next cycle only.
- REQ-021 in_valid during DRAIN SHALL be ignored; storage and wr_cnt are unchanged.
- REQ-022 Storage SHALL NOT be cleared between frames; every byte is overwritten by the next 16 column writes.
- REQ-023 Back-to-back operation SHALL be supported: 16 consecutive in_valid cycles fill the buffer in 16 cycles, and continuous out_ready drains it in 16 cycles.
- REQ-024 In FILL, out_data and out_addr SHALL be don't-care; out_last SHALL be 0.

Reset
- REQ-025 rst SHALL asynchronously force state=FILL, wr_cnt=0, rd_cnt=0, all 64 bytes=0x00, and frame_done=0.
- REQ-026 Output values during and after reset SHALL be in_ready=1, out_valid=0, out_last=0, out_addr=0, frame_done=0.
- REQ-027 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame; no frame_done SHALL be issued for it.

Structure
- REQ-028 A shared package SHALL hold the state enum (FILL, DRAIN), ROWS=8, COLS=8, NUM_COLS_IN=16 and NUM_WORDS_OUT=16.
- REQ-029 The storage array and address mapping SHALL form one sub-module, out_buff_mem (one 4-byte column write port, one 32-bit row-word read port); the FSM and counters SHALL stay in out_buff.

Verification
- REQ-030 Write columns c=0..15 with bytes {c, c+0x40, c+0x80, c+0xC0}, out_ready=1 -> words 0,2,4 = 0x03020100, 0x0B0A0908, 0x43424140; word 15 = 0xCFCECDCC with out_last=1; frame_done pulses once.
- REQ-031 Drain with out_ready=0 for 3 cycles at word 5 -> out_addr=5 and out_data held constant for 3 cycles, then word 6 follows.
- REQ-032 Assert in_valid with in_data=0xFFFFFFFF throughout DRAIN -> in_ready=0; drained words equal the fill data; the next frame starts at column 0.
- REQ-033 Assert rst after 7 columns, then write a full frame of 0x11111111 -> all 16 drained words equal 0x11111111; exactly one frame_done.
- REQ-034 Assert rst at drain word 9 -> out_valid=0 and in_ready=1 immediately; no frame_done.
- REQ-035 Run two frames back-to-back with continuous valid/ready -> 64 cycles total plus 2 FSM turnaround cycles; the second frame's data is fully replaced.

Source files
------------

// File: rtl/out_buff_pkg.sv
// out_buff shared types and geometry.
// 8x8 byte transpose buffer: 16 columns in, 16 words out.
package out_buff_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int ROWS          = 8;
  localparam int COLS          = 8;
  localparam int NUM_COLS_IN   = 16;
  localparam int NUM_WORDS_OUT = 16;

  localparam logic [3:0] LAST_COL  = 4'(NUM_COLS_IN - 1);
  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS_OUT - 1);

  typedef logic [7:0] byte_t;

  // Row hit by byte k of column col: col/8 + 2k.
  function automatic logic [2:0] wr_row(
    input logic [3:0] col,
    input logic [1:0] k
  );
    return {k, col[3]};
  endfunction

endpackage

// File: rtl/out_buff_if.sv
// out_buff bus: column write port and drain port.
// master drives requests, slave is the buffer.
interface out_buff_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        out_last;
  logic        frame_done;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    output frame_done
  );

endinterface

// File: rtl/out_buff_mem.sv
// out_buff storage: 8x8 bytes, one column write port,
// one combinational row-word read port.
module out_buff_mem
  import out_buff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_word,
  output logic [31:0] rd_data
);

  byte_t mem_q [ROWS][COLS];
  byte_t mem_d [ROWS][COLS];

  // Scatter the four bytes of a column across rows c/8+2k.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem_d[wr_row(wr_col, 2'(k))][wr_col[2:0]] =
          wr_data[8*k +: 8];
      end
    end
  end

  // Storage register, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Word w reads half a row: row w/2, cols (w%2)*4 .. +3.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < 4; b++) begin
      rd_data[8*b +: 8] = mem_q[rd_word[3:1]][{rd_word[0], 2'(b)}];
    end
  end

endmodule

// File: rtl/out_buff.sv
// out_buff top: fill/drain FSM and counters around
// the transpose storage.
module out_buff
  import out_buff_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  out_buff_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       frame_done_q, frame_done_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [31:0] rd_data;

  assign wr_fire = bus.in_valid && (state_q == FILL);
  assign rd_fire = bus.out_ready && (state_q == DRAIN);

  // Next-state, counters and done pulse.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + 4'd1;
          if (wr_cnt_q == LAST_COL) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_fire) begin
          rd_cnt_d = rd_cnt_q + 4'd1;
          if (rd_cnt_q == LAST_WORD) begin
            state_d      = FILL;
            frame_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  out_buff_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_col  (wr_cnt_q),
    .wr_data (bus.in_data),
    .rd_word (rd_cnt_q),
    .rd_data (rd_data)
  );

  assign bus.in_ready   = (state_q == FILL);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_data   = rd_data;
  assign bus.out_addr   = rd_cnt_q;
  assign bus.out_last   = (state_q == DRAIN) &&
                          (rd_cnt_q == LAST_WORD);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_out_buff.sv
// out_buff bench: random frames vs. a transpose model,
// scoreboard queue checked by a negedge monitor.
module tb_out_buff;

  logic clk = 1'b0;
  logic rst;

  out_buff_if bus ();

  out_buff dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cols[$];
  logic [31:0] seen[16];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  logic        exp_done = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endfunction

  // Transpose model: word r byte b is row r/2, col (r%2)*4+b;
  // that byte came from column (row%2)*8+col, byte row/2.
  function automatic void push_frame();
    for (int r = 0; r < 16; r++) begin
      exp_t e;
      e.addr = 4'(r);
      e.last = (r == 15);
      e.data = '0;
      for (int b = 0; b < 4; b++) begin
        int row, col, c, k;
        row = r / 2;
        col = (r % 2) * 4 + b;
        c   = (row % 2) * 8 + col;
        k   = row / 2;
        e.data[8*b +: 8] = cols[c][8*k +: 8];
      end
      sb.push_back(e);
    end
    cols.delete();
  endfunction

  // Monitor: compare DUT outputs with the scoreboard head.
  initial begin
    forever begin
      logic ev, xfer;
      @(negedge clk);
      ev = (sb.size() > 0);
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !ev);
      chk("frame_done", bus.frame_done, exp_done);
      if (bus.frame_done) done_cnt++;
      if (ev) begin
        chk("out_addr", bus.out_addr, sb[0].addr);
        chk("out_data", bus.out_data, sb[0].data);
        chk("out_last", bus.out_last, sb[0].last);
      end else begin
        chk("out_last_idle", bus.out_last, 1'b0);
      end
      xfer = bus.out_valid && bus.out_ready && ev;
      @(posedge clk);
      exp_done = 1'b0;
      if (xfer && sb.size() > 0) begin
        seen[sb[0].addr] = bus.out_data;
        if (sb[0].last) exp_done = 1'b1;
        void'(sb.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick(input int mode);
    logic [7:0] c;
    c = 8'(cols.size());
    case (mode)
      0: return {c + 8'hC0, c + 8'h80, c + 8'h40, c};
      2: return 32'h1111_1111;
      default: return $urandom;
    endcase
  endfunction

  // Write n columns; model frame is pushed every 16 accepts.
  task automatic fill_cols(input int n, input int mode,
                           input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   w;
      if (gaps && ($urandom % 4 == 0)) begin
        bus.in_valid = 1'b0;
        sync();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pick(mode);
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 100) begin
        @(negedge clk);
        acc = bus.in_ready;
        sync();
        w++;
      end
      if (!acc) begin
        chk("fill_timeout", acc, 1'b1);
        bus.in_valid = 1'b0;
        return;
      end
      cols.push_back(bus.in_data);
      if (cols.size() == 16) push_frame();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic reset_now(input bit check);
    rst = 1'b1;
    sb.delete();
    cols.delete();
    exp_done = 1'b0;
    #1;
    if (check) begin
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_last", bus.out_last, 1'b0);
      chk("rst_out_addr", bus.out_addr, 4'd0);
      chk("rst_frame_done", bus.frame_done, 1'b0);
    end
    repeat (2) sync();
    rst = 1'b0;
  endtask

  // Consume n words; optional stall, random ready, reset.
  task automatic drain_words(input int n, input int stall_at,
                             input int stall_len,
                             input int rst_at, input bit rnd);
    int got = 0;
    int st  = 0;
    int c   = 0;
    while (got < n && c < 400) begin
      logic x;
      if (got == rst_at) begin
        bus.out_ready = 1'b0;
        reset_now(1'b1);
        return;
      end
      if (got == stall_at && st < stall_len) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) st++;
      end else if (rnd) begin
        bus.out_ready = 1'($urandom % 2);
      end else begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      x = bus.out_valid && bus.out_ready;
      sync();
      if (x) got++;
      c++;
    end
    if (got < n) chk("drain_timeout", got, n);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_done(input int base, input int want);
    @(negedge clk);
    #1;
    chk("done_count", done_cnt - base, want);
    sync();
  endtask

  initial begin
    int d0, c0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_in_ready", bus.in_ready, 1'b1);
    chk("init_out_valid", bus.out_valid, 1'b0);
    chk("init_out_addr", bus.out_addr, 4'd0);
    chk("init_frame_done", bus.frame_done, 1'b0);
    rst = 1'b0;
    sync();

    // Known pattern, continuous ready.
    d0 = done_cnt;
    fill_cols(16, 0, 1'b0);
    drain_words(16, -1, 0, -1, 1'b0);
    chk("word0", seen[0], 32'h0302_0100);
    chk("word2", seen[2], 32'h0B0A_0908);
    chk("word4", seen[4], 32'h4342_4140);
    chk("word15", seen[15], 32'hCFCE_CDCC);
    check_done(d0, 1);

    // Stall three cycles on word 5.
    fill_cols(16, 1, 1'b1);
    drain_words(16, 5, 3, -1, 1'b0);
    sync();

    // Junk writes during drain are ignored.
    fill_cols(16, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    drain_words(16, -1, 0, -1, 1'b1);
    bus.in_valid = 1'b0;
    fill_cols(16, 0, 1'b1);
    drain_words(16, -1, 0, -1, 1'b1);
    sync();

    // Reset mid-fill, then a constant frame.
    fill_cols(7, 1, 1'b0);
    reset_now(1'b1);
    d0 = done_cnt;
    fill_cols(16, 2, 1'b0);
    drain_words(16, -1, 0, -1, 1'b0);
    check_done(d0, 1);

    // Reset at drain word 9: no done pulse.
    d0 = done_cnt;
    fill_cols(16, 1, 1'b0);
    drain_words(16, -1, 0, 9, 1'b0);
    repeat (3) sync();
    chk("rst_drain_no_done", done_cnt - d0, 0);

    // Two frames back-to-back.
    bus.out_ready = 1'b1;
    c0 = cyc;
    fork
      fill_cols(32, 1, 1'b0);
      drain_words(32, -1, 0, -1, 1'b0);
    join
    chk("b2b_min", (cyc - c0) >= 64, 1'b1);
    chk("b2b_max", (cyc - c0) <= 66, 1'b1);
    sync();

    // Random frames, gaps and random ready.
    for (int f = 0; f < 4; f++) begin
      fill_cols(16, 1, 1'b1);
      drain_words(16, -1, 0, -1, 1'b1);
    end
    repeat (3) sync();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
